regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port (wen/rd/din) between two writeback sources: EX (ALU results) and MEM (load data).
- Maintains a per-register busy scoreboard, set at issue and cleared when the write reaches the register file.
- Produces an issue stall for RAW/WAW hazards.
- Sits between the pipeline's writeback stage and RegisterFile; its wen/rd/din outputs drive RegisterFile directly.

Parameters:
- XLEN, 32, data width of writeback and register-file din.
- AW, 5, register address width (2**AW registers; x0 hardwired zero).
- STARVE_MAX, 3, consecutive cycles EX may lose arbitration before it is forced to win.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- issue_valid, input, 1, instruction issuing this cycle that will write issue_rd.
- issue_rd, input, AW, destination of issuing instruction.
- rs1, input, AW, source 1 of issuing instruction.
- rs2, input, AW, source 2 of issuing instruction.
- stall, output, 1, combinational hazard flag for the issue stage.
- ex_valid, input, 1, EX writeback request.
- ex_rd, input, AW, EX destination.
- ex_data, input, XLEN, EX result.
- ex_ready, output, 1, EX request accepted this cycle.
- mem_valid, input, 1, MEM writeback request.
- mem_rd, input, AW, MEM destination.
- mem_data, input, XLEN, MEM load data.
- mem_ready, output, 1, MEM request accepted this cycle.
- wen, output, 1, register-file write enable (registered).
- rd, output, AW, register-file write address (registered).
- din, output, XLEN, register-file write data (registered).
- busy_vec, output, 2**AW, scoreboard state; bit 0 is always 0.

Behaviour:
- Reset (rst_n low, async): wen=0, rd=0, din=0, busy_vec=0, starve_cnt=0. Any accepted-but-unwritten result is dropped. Outputs hold these values until the first rising edge after deassertion.
- Handshake: a transfer occurs on a cycle where valid&ready are both high. At most one grant per cycle. ready is combinational from valid and starve_cnt. A requester holds valid/rd/data stable until ready.
- Grant rule:
  - Only one valid: that source is granted.
  - Both valid and starve_cnt<STARVE_MAX: MEM is granted.
  - Both valid and starve_cnt==STARVE_MAX: EX is granted.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments (saturating) when ex_valid and MEM is granted.
  - Clears when EX is granted or ex_valid is low.
- Write latency: a grant at cycle t loads rd/din and sets wen at edge t+1. RegisterFile commits at edge t+2.
  - A granted rd of 0 still handshakes, but wen stays 0 (write to x0 is suppressed).
  - With no grant, wen=0 at the next edge; rd/din hold their previous values.
- Scoreboard, per register k≠0, each edge:
  - Set if issue_valid && !stall && issue_rd==k.
  - Else clear if wen && rd==k (the edge at which the register file commits).
  - Set and clear on the same k in the same cycle: set wins.
  - busy[0] is never set.
- stall = issue_valid && ((rs1≠0 && busy[rs1]) || (rs2≠0 && busy[rs2]) || (issue_rd≠0 && busy[issue_rd])).
  - There is no forwarding: a dependent issues no earlier than the cycle after busy clears, when the register file already holds the data.
- Neither writeback port depends on stall. A writeback for a register that is not busy is still performed.

Test Plan:
- Reset mid-write: MEM grants x10=0xBABEFACE, rst_n is pulsed low before edge t+1 -> wen=0, rd=0, din=0, busy_vec=0 immediately; x10 is never written.
- Single EX write: issue rd=10 (busy[10]=1); EX x10=0xBABEFACE at cycle 3 -> ex_ready=1 at cycle 3; wen=1, rd=10, din=0xBABEFACE in cycle 4; busy[10]=0 from cycle 5; issue with rs1=10 stalls through cycle 4 and issues at cycle 5.
- Conflict and starvation, STARVE_MAX=3: ex_valid and mem_valid held high for 5 cycles -> grants are M,M,M,E,M; starve_cnt sequence is 1,2,3,0,1.
- x0 suppression: EX rd=0, data=0xFFFFFFFF -> ex_ready=1, wen stays 0, busy_vec unchanged.
- Simultaneous set/clear: wen=1 with rd=2 on the same cycle as a stall-free issue with issue_rd=2 -> busy[2] remains 1 after the edge.
- WAW stall: busy[5]=1 and issue_rd=5 with rs1=rs2=0 -> stall=1 until busy[5] clears.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the issue-side, writeback-side and register-file-side signals
// around the writeback arbiter. The arbiter takes the slave view, while the
// pipeline (or a bench) driving requests and consuming results takes the master view.
//
// Signal summary:
//   issue_valid/issue_rd/rs1/rs2 -> stall        issue-stage hazard query
//   ex_valid/ex_rd/ex_data       -> ex_ready     EX writeback request
//   mem_valid/mem_rd/mem_data    -> mem_ready    MEM writeback request
//   wen/rd/din                                   register-file write port
//   busy_vec                                     per-register scoreboard
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Issue stage
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              stall;

    // EX writeback source
    logic              ex_valid;
    logic [AW-1:0]     ex_rd;
    logic [XLEN-1:0]   ex_data;
    logic              ex_ready;

    // MEM writeback source
    logic              mem_valid;
    logic [AW-1:0]     mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              mem_ready;

    // Register-file write port and scoreboard view
    logic              wen;
    logic [AW-1:0]     rd;
    logic [XLEN-1:0]   din;
    logic [2**AW-1:0]  busy_vec;

    // Pipeline / stimulus side
    modport master (
        output issue_valid, issue_rd, rs1, rs2,
        output ex_valid, ex_rd, ex_data,
        output mem_valid, mem_rd, mem_data,
        input  stall, ex_ready, mem_ready,
        input  wen, rd, din, busy_vec
    );

    // Arbiter side
    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
        input  ex_valid, ex_rd, ex_data,
        input  mem_valid, mem_rd, mem_data,
        output stall, ex_ready, mem_ready,
        output wen, rd, din, busy_vec
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrate the single register-file write port between EX and MEM
//          writeback, track per-register busy state and flag issue hazards.
// Latency: grant at cycle t -> wen/rd/din registered at edge t+1; the register
//          file commits at edge t+2, which is also when busy clears.
// Backpressure: ready is combinational from valid and the starvation counter;
//          MEM wins conflicts unless EX has lost STARVE_MAX times in a row.
//          Writeback ports never depend on stall.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus (slave)  issue query, EX/MEM writeback handshakes, register-file
//                write port (wen/rd/din) and busy_vec scoreboard output
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NREG = 2 ** AW;
    // Counter must be able to hold STARVE_MAX itself.
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            wen_q,        wen_d;
    logic [AW-1:0]   rd_q,         rd_d;
    logic [XLEN-1:0] din_q,        din_d;
    logic [NREG-1:0] busy_q,       busy_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic            ex_gnt;
    logic            mem_gnt;
    logic            any_gnt;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;

    always_comb begin
        ex_gnt  = 1'b0;
        mem_gnt = 1'b0;
        // EX wins when alone, or when it has been starved long enough.
        if (bus.ex_valid && (!bus.mem_valid || (starve_cnt_q == STARVE_LIMIT))) begin
            ex_gnt = 1'b1;
        end else if (bus.mem_valid) begin
            mem_gnt = 1'b1;
        end
        any_gnt  = ex_gnt || mem_gnt;
        gnt_rd   = ex_gnt ? bus.ex_rd   : bus.mem_rd;
        gnt_data = ex_gnt ? bus.ex_data : bus.mem_data;
    end

    // Starvation counter: counts consecutive cycles EX waited behind MEM.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.ex_valid || ex_gnt) begin
            starve_cnt_d = '0;
        end else if (mem_gnt && (starve_cnt_q != STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write-port register stage
    // ------------------------------------------------------------------
    always_comb begin
        wen_d = 1'b0;
        rd_d  = rd_q;
        din_d = din_q;
        if (any_gnt) begin
            rd_d  = gnt_rd;
            din_d = gnt_data;
            // x0 is hardwired: the transfer completes but nothing is written.
            wen_d = (gnt_rd != '0);
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and scoreboard
    // ------------------------------------------------------------------
    logic            src1_hz;
    logic            src2_hz;
    logic            dst_hz;
    logic            stall_int;
    logic            issue_fire;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        src1_hz   = (bus.rs1      != '0) && busy_q[bus.rs1];
        src2_hz   = (bus.rs2      != '0) && busy_q[bus.rs2];
        dst_hz    = (bus.issue_rd != '0) && busy_q[bus.issue_rd];
        stall_int = bus.issue_valid && (src1_hz || src2_hz || dst_hz);
        issue_fire = bus.issue_valid && !stall_int;
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_fire && (bus.issue_rd != '0)) begin
            set_vec[bus.issue_rd] = 1'b1;
        end
        // Busy clears on the edge where the register file commits wen/rd.
        if (wen_q) begin
            clr_vec[rd_q] = 1'b1;
        end
        // A new issue to the same register keeps it busy: set beats clear.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            wen_q        <= 1'b0;
            rd_q         <= '0;
            din_q        <= '0;
            busy_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            rd_q         <= rd_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall     = stall_int;
    assign bus.ex_ready  = ex_gnt;
    assign bus.mem_ready = mem_gnt;
    assign bus.wen       = wen_q;
    assign bus.rd        = rd_q;
    assign bus.din       = din_q;
    assign bus.busy_vec  = busy_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_gnt && mem_gnt));
    a_x0_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !busy_q[0]);
    a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
        !(wen_q && (rd_q == '0)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: each task drives one scenario and
// compares DUT outputs against hand-computed values.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.ex_valid    = 1'b0;
        bus.ex_rd       = '0;
        bus.ex_data     = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %0h expected 0", bus.wen); end
        checks++; if (bus.rd !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0h expected 0", bus.rd); end
        checks++; if (bus.din !== 32'd0) begin failures++; $display("FAIL reset_din: got %0h expected 0", bus.din); end
        checks++; if (bus.busy_vec !== 32'd0) begin failures++; $display("FAIL reset_busy: got %0h expected 0", bus.busy_vec); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0h expected 0", bus.stall); end
        do_reset();
    endtask

    task automatic test_reset_mid_write;
        do_reset();
        // Make x10 busy and put a non-zero value on the write port.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        tick();
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_data = 32'h0000_1234;
        tick();
        bus.ex_valid = 1'b0;
        checks++; if (bus.din !== 32'h0000_1234) begin failures++; $display("FAIL pre_reset_din: got %0h expected 1234", bus.din); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'hBABE_FACE;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL midrst_mem_ready: got %0h expected 1", bus.mem_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL midrst_wen: got %0h expected 0", bus.wen); end
        checks++; if (bus.rd !== 5'd0) begin failures++; $display("FAIL midrst_rd: got %0h expected 0", bus.rd); end
        checks++; if (bus.din !== 32'd0) begin failures++; $display("FAIL midrst_din: got %0h expected 0", bus.din); end
        checks++; if (bus.busy_vec !== 32'd0) begin failures++; $display("FAIL midrst_busy: got %0h expected 0", bus.busy_vec); end
        bus.mem_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.wen !== 1'b0 || bus.din !== 32'd0) begin failures++; $display("FAIL midrst_after: got wen=%0h din=%0h expected wen=0 din=0", bus.wen, bus.din); end
    endtask

    task automatic test_single_ex;
        do_reset();
        // cycle 1: issue rd=10
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ex_issue_stall: got %0h expected 0", bus.stall); end
        tick();
        // cycle 2: dependent rs1=10 must stall
        checks++; if (bus.busy_vec[10] !== 1'b1) begin failures++; $display("FAIL ex_busy_set: got %0h expected 1", bus.busy_vec[10]); end
        bus.issue_rd = 5'd11; bus.rs1 = 5'd10;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ex_raw_stall_c2: got %0h expected 1", bus.stall); end
        tick();
        // cycle 3: EX request
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd10; bus.ex_data = 32'hBABE_FACE;
        #1;
        checks++; if (bus.ex_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin failures++; $display("FAIL ex_ready: got ex=%0h mem=%0h expected ex=1 mem=0", bus.ex_ready, bus.mem_ready); end
        tick();
        // cycle 4: write port presents the result
        bus.ex_valid = 1'b0;
        checks++; if (bus.wen !== 1'b1 || bus.rd !== 5'd10 || bus.din !== 32'hBABE_FACE) begin failures++; $display("FAIL ex_wport: got wen=%0h rd=%0d din=%0h expected wen=1 rd=10 din=babeface", bus.wen, bus.rd, bus.din); end
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL ex_raw_stall_c4: got %0h expected 1", bus.stall); end
        tick();
        // cycle 5: busy cleared, dependent issues
        checks++; if (bus.busy_vec[10] !== 1'b0 || bus.wen !== 1'b0) begin failures++; $display("FAIL ex_busy_clr: got busy=%0h wen=%0h expected 0 0", bus.busy_vec[10], bus.wen); end
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ex_raw_release: got %0h expected 0", bus.stall); end
        tick();
        idle();
        checks++; if (bus.busy_vec !== 32'h0000_0800) begin failures++; $display("FAIL ex_dep_issued: got %0h expected 800", bus.busy_vec); end
    endtask

    task automatic test_conflict;
        bit exp_e [5];
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.ex_valid  = 1'b1; bus.ex_rd  = 5'd3; bus.ex_data  = 32'hEEEE_0003;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hAAAA_0004;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.ex_ready !== exp_e[i] || bus.mem_ready !== !exp_e[i]) begin failures++; $display("FAIL conflict_grant[%0d]: got ex=%0h mem=%0h expected ex=%0h", i, bus.ex_ready, bus.mem_ready, exp_e[i]); end
            tick();
            checks++; if (bus.wen !== 1'b1 || bus.rd !== (exp_e[i] ? 5'd3 : 5'd4) || bus.din !== (exp_e[i] ? 32'hEEEE_0003 : 32'hAAAA_0004)) begin failures++; $display("FAIL conflict_wport[%0d]: got wen=%0h rd=%0d din=%0h", i, bus.wen, bus.rd, bus.din); end
        end
        idle();
        tick();
        checks++; if (bus.wen !== 1'b0 || bus.rd !== 5'd4 || bus.din !== 32'hAAAA_0004) begin failures++; $display("FAIL conflict_hold: got wen=%0h rd=%0d din=%0h expected wen=0 rd=4 din=aaaa0004", bus.wen, bus.rd, bus.din); end
    endtask

    task automatic test_x0;
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL x0_ready: got %0h expected 1", bus.ex_ready); end
        tick();
        bus.ex_valid = 1'b0;
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL x0_wen: got %0h expected 0", bus.wen); end
        checks++; if (bus.busy_vec !== 32'h0000_0080) begin failures++; $display("FAIL x0_busy: got %0h expected 80", bus.busy_vec); end
        tick();
        checks++; if (bus.busy_vec !== 32'h0000_0080) begin failures++; $display("FAIL x0_busy_next: got %0h expected 80", bus.busy_vec); end
    endtask

    task automatic test_set_clear;
        do_reset();
        // Write x2 while it is not busy, then issue to x2 during its wen cycle.
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd2; bus.ex_data = 32'h2222_2222;
        tick();
        bus.ex_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
        #1;
        checks++; if (bus.wen !== 1'b1 || bus.rd !== 5'd2 || bus.stall !== 1'b0) begin failures++; $display("FAIL setclr_pre: got wen=%0h rd=%0d stall=%0h expected 1 2 0", bus.wen, bus.rd, bus.stall); end
        tick();
        idle();
        checks++; if (bus.busy_vec !== 32'h0000_0004) begin failures++; $display("FAIL setclr_busy: got %0h expected 4", bus.busy_vec); end
        tick();
        checks++; if (bus.busy_vec !== 32'h0000_0004) begin failures++; $display("FAIL setclr_busy_hold: got %0h expected 4", bus.busy_vec); end
    endtask

    task automatic test_waw;
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        tick();
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL waw_stall0: got %0h expected 1", bus.stall); end
        tick();
        checks++; if (bus.busy_vec !== 32'h0000_0020) begin failures++; $display("FAIL waw_busy: got %0h expected 20", bus.busy_vec); end
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'h5555_5555;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.stall !== 1'b1) begin failures++; $display("FAIL waw_grant: got mem_ready=%0h stall=%0h expected 1 1", bus.mem_ready, bus.stall); end
        tick();
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL waw_stall_wen: got %0h expected 1", bus.stall); end
        tick();
        checks++; if (bus.busy_vec !== 32'd0 || bus.stall !== 1'b0) begin failures++; $display("FAIL waw_release: got busy=%0h stall=%0h expected 0 0", bus.busy_vec, bus.stall); end
        tick();
        idle();
        checks++; if (bus.busy_vec !== 32'h0000_0020) begin failures++; $display("FAIL waw_reissue: got %0h expected 20", bus.busy_vec); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        test_reset();
        test_reset_mid_write();
        test_single_ex();
        test_conflict();
        test_x0();
        test_set_clear();
        test_waw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
